bitcheck_seq: RTL and testbench

- Parametrised, sequential successor to the combinational 32-bit bit checker.
- Accepts one DATA_W-bit word per transaction over a valid/ready handshake and scans it STEP bits per cycle.
- Reports one of four bit statistics selected per transaction by `fun`.
- Sits between a word producer (register file or bus slave) and a result consumer; both sides are backpressure-capable.

---
 rtl/bitcheck_pkg.sv | 27 ++
 rtl/bitcheck_step.sv | 37 +++
 rtl/bitcheck_seq.sv | 136 +++++++++++++
 tb/tb_bitcheck_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bitcheck_pkg.sv
// Shared definitions for the sequential bit checker.
// Contents: mode encodings carried on `fun`, FSM state encoding, and a
// constant-evaluable clog2 used to size counters from parameters.
package bitcheck_pkg;

  localparam logic [1:0] MODE_EVEN   = 2'b00;
  localparam logic [1:0] MODE_ODD    = 2'b01;
  localparam logic [1:0] MODE_POPCNT = 2'b10;
  localparam logic [1:0] MODE_MAXRUN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitcheck_step.sv
// One scan slice of the bit checker (purely combinational).
// Ports:
//   bits    : STEP bits to process, bit 0 first
//   cur_in  : length of the run of ones ending just before bits[0]
//   max_in  : longest run seen so far
//   ones    : number of ones in this slice
//   cur_out : run length after the last bit of the slice
//   max_out : longest run after the slice
module bitcheck_step #(
  parameter int STEP = 4,
  parameter int CW   = 6
) (
  input  logic [STEP-1:0] bits,
  input  logic [CW-1:0]   cur_in,
  input  logic [CW-1:0]   max_in,
  output logic [CW-1:0]   ones,
  output logic [CW-1:0]   cur_out,
  output logic [CW-1:0]   max_out
);

  always_comb begin
    ones    = '0;
    cur_out = cur_in;
    max_out = max_in;
    for (int i = 0; i < STEP; i++) begin
      if (bits[i]) begin
        ones    = ones + CW'(1);
        cur_out = cur_out + CW'(1);
      end else begin
        cur_out = '0;
      end
      // Updated after every bit so a run ending mid-slice is still seen.
      if (cur_out > max_out) max_out = cur_out;
    end
  end

endmodule

// File: rtl/bitcheck_seq.sv
// Sequential bit checker: accepts one DATA_W-bit word, scans it STEP bits
// per cycle, and returns parity, popcount or longest run of ones.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : input handshake carrying date/fun
//   date, fun           : word to check and statistic selector
//   out_valid, out_ready: output handshake carrying result
//   result              : zero-extended statistic
//   busy                : high while a word is in flight (SCAN or DONE)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload stable until then, and result is
// held stable while out_valid is high and out_ready is low.
module bitcheck_seq
  import bitcheck_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] date,
  input  logic [1:0]        fun,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int N   = DATA_W / STEP;
  localparam int CW  = clog2(DATA_W + 1);
  localparam int CYW = (N > 1) ? clog2(N) : 1;

  state_t state, state_nxt;

  logic [DATA_W-1:0] shreg;
  logic [1:0]        mode;
  logic [CW-1:0]     count, cur_run, max_run;
  logic [CYW-1:0]    cyc;

  logic [CW-1:0]     slice_ones, cur_nxt, max_nxt, count_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic              last_scan;

  bitcheck_step #(
    .STEP (STEP),
    .CW   (CW)
  ) u_step (
    .bits    (shreg[STEP-1:0]),
    .cur_in  (cur_run),
    .max_in  (max_run),
    .ones    (slice_ones),
    .cur_out (cur_nxt),
    .max_out (max_nxt)
  );

  assign count_nxt = count + slice_ones;
  // cyc counts completed scan cycles, so the N-th cycle sees cyc == N-1.
  assign last_scan = (cyc == CYW'(N - 1));

  // Result is formed from this cycle's step outputs so the final slice is
  // included without an extra cycle.
  always_comb begin
    result_nxt = '0;
    case (mode)
      MODE_EVEN:   result_nxt[0] = ~count_nxt[0];
      MODE_ODD:    result_nxt[0] = count_nxt[0];
      MODE_POPCNT: result_nxt    = DATA_W'(count_nxt);
      default:     result_nxt    = DATA_W'(max_nxt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_scan) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      mode    <= '0;
      count   <= '0;
      cur_run <= '0;
      max_run <= '0;
      cyc     <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg   <= date;
            mode    <= fun;
            count   <= '0;
            cur_run <= '0;
            max_run <= '0;
            cyc     <= '0;
          end
        end
        S_SCAN: begin
          shreg   <= shreg >> STEP;
          count   <= count_nxt;
          cur_run <= cur_nxt;
          max_run <= max_nxt;
          cyc     <= cyc + CYW'(1);
          if (last_scan) result <= result_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcheck_seq.sv
module tb_bitcheck_seq;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // ---------------- main DUT (defaults) ----------------
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] date, result;
  logic [1:0]  fun;

  bitcheck_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .date(date), .fun(fun), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  // ---------------- alternate configs: [0] STEP=1, [1] STEP=8 ----------------
  logic       a_in_valid[2], a_in_ready[2], a_out_valid[2], a_busy[2];
  logic [7:0] a_date[2], a_result[2];
  logic [1:0] a_fun[2];

  bitcheck_seq #(.DATA_W(8), .STEP(1)) dut_s1 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid[0]), .in_ready(a_in_ready[0]),
    .date(a_date[0]), .fun(a_fun[0]), .out_valid(a_out_valid[0]), .out_ready(1'b1),
    .result(a_result[0]), .busy(a_busy[0])
  );

  bitcheck_seq #(.DATA_W(8), .STEP(8)) dut_s8 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid[1]), .in_ready(a_in_ready[1]),
    .date(a_date[1]), .fun(a_fun[1]), .out_valid(a_out_valid[1]), .out_ready(1'b1),
    .result(a_result[1]), .busy(a_busy[1])
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_bp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: statistics computed directly from the word's bits.
  function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [1:0] f);
    int ones, run, best;
    ones = 0; run = 0; best = 0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        ones++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    case (f)
      2'b00:   return 32'((ones % 2) == 0);
      2'b01:   return 32'(ones % 2);
      2'b10:   return 32'(ones);
      default: return 32'(best);
    endcase
  endfunction

  // ---------------- monitor ----------------
  bit prev_v = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 0;
    end else begin
      if (out_valid && !prev_v) begin
        if (lat_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
        else chk("latency", 32'(edge_n - lat_q.pop_front()), 32'(N));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_result", 32'(out_valid), 32'd0);
        else chk("result", result, exp_q.pop_front());
      end
      prev_v = out_valid && !out_ready;
    end
  end

  // Random backpressure, changed away from the sampling edge.
  always begin
    @(posedge clk);
    #2;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready(input logic v);
    @(posedge clk);
    #2;
    out_ready = v;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] f);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    date     = d;
    fun      = f;
    for (int w = 0; w < 200 && !ok; w++) begin
      if (in_ready) begin
        ok = 1;
        exp_q.push_back(ref_result(d, f));
        @(posedge clk);
        #1;
        lat_q.push_back(edge_n);
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the word in flight must not care.
        fun  = 2'($urandom_range(0, 3));
        date = $urandom;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("send_accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic alt_run(input int k, input logic [7:0] d, input logic [1:0] f, input int lat);
    int acc;
    @(negedge clk);
    chk("alt_in_ready", 32'(a_in_ready[k]), 32'd1);
    a_in_valid[k] = 1'b1;
    a_date[k]     = d;
    a_fun[k]      = f;
    @(posedge clk);
    #1;
    acc = edge_n;
    a_in_valid[k] = 1'b0;
    a_fun[k]      = ~f;
    for (int i = 0; i < 50 && !a_out_valid[k]; i++) @(negedge clk);
    chk("alt_valid", 32'(a_out_valid[k]), 32'd1);
    chk("alt_latency", 32'(edge_n - acc), 32'(lat));
    chk("alt_result", 32'(a_result[k]), ref_result({24'd0, d}, f));
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] dir_d[11] = '{32'h00000109, 32'h00000109, 32'h00000109, 32'h00000109,
                             32'hF0F0FF00, 32'hF0F0FF00, 32'h00000FF0, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h00000000, 32'h00000000};
  logic [1:0]  dir_f[11] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11,
                             2'b10, 2'b00, 2'b10};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    date      = '0;
    fun       = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_in_valid[k] = 1'b0;
      a_date[k]     = '0;
      a_fun[k]      = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Directed words from the plan and boundaries.
    for (int i = 0; i < 11; i++) send(dir_d[i], dir_f[i]);

    // Randomized words under random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $urandom & $urandom;
        2:       d = $urandom | $urandom;
        default: d = 32'hFFFFFFFF >> $urandom_range(0, 31);
      endcase
      send(d, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) @(negedge clk);
    rand_bp = 0;
    set_ready(1'b1);

    // Backpressure: hold the result in DONE with another word pending.
    set_ready(1'b0);
    send(32'h0FF0_0F0F, 2'b11);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    date     = 32'h1234_5678;
    fun      = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", result, ref_result(32'h0FF0_0F0F, 2'b11));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    set_ready(1'b1);
    send(32'h1234_5678, 2'b10);

    // Reset mid-scan aborts the word.
    send(32'hDEAD_BEEF, 2'b10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < N + 4; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
    end
    send(32'h0000_0007, 2'b10);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Alternate configurations.
    alt_run(0, 8'hB6, 2'b10, 8);
    alt_run(0, 8'hB6, 2'b11, 8);
    alt_run(1, 8'hB6, 2'b10, 1);
    alt_run(1, 8'hB6, 2'b11, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
